// File: rtl/uart_frame_tx_sched_if.sv
// Signal bundle between the frame/message scheduler, the TX frame RAM, the
// status requester and uart_tx. The scheduler takes the master side.
interface uart_frame_tx_sched_if #(
    parameter int ADDR_W = 13
);
    logic              frame_tick;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              msg_valid;
    logic [7:0]        msg_data;
    logic              msg_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic              busy;
    logic              frame_sent;
    logic              overrun;
    logic [3:0]        dbg_state;

    modport master (
        input  frame_tick, rd_data, msg_valid, msg_data, tx_busy, tx_done,
        output rd_en, rd_addr, msg_ready, tx_start, tx_data, busy, frame_sent,
               overrun, dbg_state
    );

    modport slave (
        output frame_tick, rd_data, msg_valid, msg_data, tx_busy, tx_done,
        input  rd_en, rd_addr, msg_ready, tx_start, tx_data, busy, frame_sent,
               overrun, dbg_state
    );
endinterface

// File: rtl/uart_frame_tx_sched.sv
// Owns the single uart_tx byte transmitter: streams one packed edge-map frame
// as sync/length/payload/checksum and slots single status bytes between frames.
module uart_frame_tx_sched #(
    parameter int         FRAME_BYTES = 5280,
    parameter int         ADDR_W      = 13,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A
) (
    input logic                   clk,
    input logic                   reset,
    uart_frame_tx_sched_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, MSG, HDR, RD, RDW, SEND, WAIT, CSUM, CWAIT
    } state_t;

    localparam logic [15:0] LEN  = 16'(FRAME_BYTES);
    localparam logic [15:0] LAST = 16'(FRAME_BYTES - 1);

    state_t            state_q, state_d;
    logic              issued_q, issued_d;
    logic [1:0]        hcnt_q, hcnt_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              pending_q, pending_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              frame_sent_q, frame_sent_d;
    logic              overrun_q, overrun_d;

    logic              tx_start_c;
    logic              msg_ready_c;
    logic              rd_en_c;
    logic              frame_active;
    logic              start_frame;
    logic [ADDR_W-1:0] rd_addr_c;

    function automatic logic [7:0] hdr_byte(input logic [1:0] n);
        case (n)
            2'd0:    return SYNC0;
            2'd1:    return SYNC1;
            2'd2:    return LEN[15:8];
            default: return LEN[7:0];
        endcase
    endfunction

    // Handshakes: a status byte moves on the cycle msg_valid && msg_ready, and
    // the requester holds msg_data until then. tx_start is a single-cycle
    // request that is only raised while tx_busy is low; tx_data then stays
    // put until the matching tx_done pulse.
    assign rd_addr_c = (state_q == RD) ? idx_q[ADDR_W-1:0] : rd_addr_q;

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        hcnt_d       = hcnt_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        pending_d    = pending_q;
        tx_data_d    = tx_data_q;
        rd_addr_d    = rd_addr_c;
        frame_sent_d = 1'b0;
        overrun_d    = 1'b0;
        tx_start_c   = 1'b0;
        msg_ready_c  = 1'b0;
        rd_en_c      = 1'b0;
        start_frame  = 1'b0;
        frame_active = (state_q inside {HDR, RD, RDW, SEND, WAIT, CSUM, CWAIT});

        // Only one frame can be queued; anything beyond that is reported and dropped.
        if (bus.frame_tick) begin
            if (frame_active || pending_q) overrun_d = 1'b1;
            else                           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!bus.tx_busy) begin
                    if (pending_q || bus.frame_tick) begin
                        start_frame = 1'b1;
                    end else if (bus.msg_valid) begin
                        state_d   = MSG;
                        issued_d  = 1'b0;
                        tx_data_d = bus.msg_data;
                    end
                end
            end
            MSG: begin
                if (!issued_q) begin
                    if (!bus.tx_busy) begin
                        tx_start_c  = 1'b1;
                        msg_ready_c = 1'b1;
                        issued_d    = 1'b1;
                    end
                end else if (bus.tx_done) begin
                    // A frame queued behind this byte starts right away.
                    if (pending_q || bus.frame_tick) start_frame = 1'b1;
                    else                             state_d     = IDLE;
                end
            end
            HDR: begin
                if (!issued_q) begin
                    if (!bus.tx_busy) begin
                        tx_start_c = 1'b1;
                        issued_d   = 1'b1;
                    end
                end else if (bus.tx_done) begin
                    issued_d = 1'b0;
                    if (hcnt_q == 2'd3) begin
                        state_d = RD;
                        idx_d   = '0;
                    end else begin
                        hcnt_d    = hcnt_q + 2'd1;
                        tx_data_d = hdr_byte(hcnt_q + 2'd1);
                    end
                end
            end
            RD: begin
                rd_en_c = 1'b1;
                state_d = RDW;
            end
            RDW: begin
                tx_data_d = bus.rd_data;
                state_d   = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_c = 1'b1;
                    csum_d     = csum_q + tx_data_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.tx_done) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == LAST) begin
                        state_d   = CSUM;
                        tx_data_d = csum_q;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            CSUM: begin
                if (!bus.tx_busy) begin
                    tx_start_c = 1'b1;
                    state_d    = CWAIT;
                end
            end
            CWAIT: begin
                if (bus.tx_done) begin
                    frame_sent_d = 1'b1;
                    csum_d       = '0;
                    idx_d        = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d   = HDR;
            pending_d = 1'b0;
            issued_d  = 1'b0;
            hcnt_d    = 2'd0;
            tx_data_d = SYNC0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            issued_q     <= 1'b0;
            hcnt_q       <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            pending_q    <= 1'b0;
            tx_data_q    <= '0;
            rd_addr_q    <= '0;
            frame_sent_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            hcnt_q       <= hcnt_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            pending_q    <= pending_d;
            tx_data_q    <= tx_data_d;
            rd_addr_q    <= rd_addr_d;
            frame_sent_q <= frame_sent_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = rd_addr_c;
    assign bus.msg_ready  = msg_ready_c;
    assign bus.tx_start   = tx_start_c;
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_sent = frame_sent_q;
    assign bus.overrun    = overrun_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_uart_frame_tx_sched.sv
// Bench for uart_frame_tx_sched: RAM and uart_tx models, byte scoreboard,
// table of frame payloads plus hand-written arbitration/overrun/reset sequences.
module tb_uart_frame_tx_sched;
    localparam int FB       = 4;
    localparam int AW       = 4;
    localparam int UART_CYC = 6;

    typedef struct {
        logic [31:0] ram_word;
        logic [7:0]  csum;
    } vec_t;

    logic clk;
    logic reset;

    uart_frame_tx_sched_if #(.ADDR_W(AW)) bus ();

    uart_frame_tx_sched #(
        .FRAME_BYTES(FB), .ADDR_W(AW), .SYNC0(8'hA5), .SYNC1(8'h5A)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [7:0] ram [16];
    int         uart_cnt;
    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    int         done_cyc_q[$];
    int         rd_log[$];
    int         cyc;
    int         tx_start_cnt, frame_sent_cnt, frame_sent_cyc, overrun_cnt;
    int         msg_ready_cnt, msg_ready_cyc, rd_en_cnt;
    logic [7:0] last_tx;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // RAM: data valid the cycle after rd_en
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    // uart_tx model: UART_CYC busy cycles, tx_done pulses as busy falls
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
            uart_cnt    <= 0;
        end else begin
            bus.tx_done <= 1'b0;
            if (bus.tx_busy) begin
                uart_cnt <= uart_cnt - 1;
                if (uart_cnt == 1) begin
                    bus.tx_busy <= 1'b0;
                    bus.tx_done <= 1'b1;
                end
            end else if (bus.tx_start) begin
                bus.tx_busy <= 1'b1;
                uart_cnt    <= UART_CYC;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0h, expected no such event", name, act);
    endtask

    // scoreboard / event monitor, sampled on the falling edge
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (bus.tx_start) begin
                    tx_start_cnt++;
                    start_cyc_q.push_back(cyc);
                    last_tx = bus.tx_data;
                    check("tx_start_vs_busy", int'(bus.tx_busy), 0);
                    if (exp_q.size() == 0) note_fail("unexpected_tx_start", int'(bus.tx_data));
                    else check("tx_byte", int'(bus.tx_data), int'(exp_q.pop_front()));
                end
                if (bus.tx_done) begin
                    done_cyc_q.push_back(cyc);
                    check("tx_data_stable", int'(bus.tx_data), int'(last_tx));
                end
                if (bus.frame_sent) begin
                    frame_sent_cnt++;
                    frame_sent_cyc = cyc;
                end
                if (bus.overrun) overrun_cnt++;
                if (bus.msg_ready) begin
                    msg_ready_cnt++;
                    msg_ready_cyc = cyc;
                end
                if (bus.rd_en) begin
                    rd_en_cnt++;
                    rd_log.push_back(int'(bus.rd_addr));
                end
            end
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic load_ram(input logic [31:0] w);
        ram[0] = w[31:24];
        ram[1] = w[23:16];
        ram[2] = w[15:8];
        ram[3] = w[7:0];
    endtask

    task automatic push_frame(input logic [31:0] w, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(FB >> 8));
        exp_q.push_back(8'(FB & 255));
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(cs);
    endtask

    task automatic clear_logs();
        start_cyc_q.delete();
        done_cyc_q.delete();
        rd_log.delete();
        tx_start_cnt   = 0;
        frame_sent_cnt = 0;
        frame_sent_cyc = 0;
        overrun_cnt    = 0;
        msg_ready_cnt  = 0;
        msg_ready_cyc  = 0;
        rd_en_cnt      = 0;
    endtask

    task automatic wait_sent(input int budget);
        int n = 0;
        while (frame_sent_cnt < 1 && n < budget) begin
            step(1);
            n++;
        end
        if (frame_sent_cnt < 1) note_fail("frame_sent_timeout", frame_sent_cnt);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (tx_start_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        if (tx_start_cnt < target) note_fail("tx_start_timeout", tx_start_cnt);
    endtask

    task automatic wait_msg_ready(input int budget);
        int n = 0;
        while (msg_ready_cnt < 1 && n < budget) begin
            step(1);
            n++;
        end
        if (msg_ready_cnt < 1) note_fail("msg_ready_timeout", msg_ready_cnt);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (done_cyc_q.size() < target && n < budget) begin
            step(1);
            n++;
        end
        if (done_cyc_q.size() < target) note_fail("tx_done_timeout", done_cyc_q.size());
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_tx_start"},   int'(bus.tx_start), 0);
        check({tag, "_tx_data"},    int'(bus.tx_data), 0);
        check({tag, "_rd_en"},      int'(bus.rd_en), 0);
        check({tag, "_rd_addr"},    int'(bus.rd_addr), 0);
        check({tag, "_msg_ready"},  int'(bus.msg_ready), 0);
        check({tag, "_busy"},       int'(bus.busy), 0);
        check({tag, "_frame_sent"}, int'(bus.frame_sent), 0);
        check({tag, "_overrun"},    int'(bus.overrun), 0);
        check({tag, "_state"},      int'(bus.dbg_state), 0);
    endtask

    task automatic check_frame_timing();
        if (start_cyc_q.size() >= 9 && done_cyc_q.size() >= 9) begin
            check("hdr_gap", start_cyc_q[1] - done_cyc_q[0], 1);
            check("payload_gap", start_cyc_q[5] - done_cyc_q[4], 3);
            check("frame_sent_delay", frame_sent_cyc - done_cyc_q[8], 1);
        end else begin
            note_fail("frame_event_count", start_cyc_q.size());
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h01020304, 8'h0A};
        vecs[1] = '{32'hFFFFFFFF, 8'hFC};
        vecs[2] = '{32'h00000000, 8'h00};
        vecs[3] = '{32'h80808080, 8'h00};
        vecs[4] = '{32'h12345678, 8'h14};
        vecs[5] = '{32'hF0E1D2C3, 8'h66};

        total          = 0;
        bad            = 0;
        cyc            = 0;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.msg_valid  = 1'b0;
        bus.msg_data   = 8'h00;
        clear_logs();
        fork
            monitor_loop();
        join_none

        // power-on reset and idle with no stimulus
        step(3);
        check_quiet_outputs("reset");
        reset = 1'b0;
        step(20);
        check("idle_no_start", tx_start_cnt, 0);
        check("idle_busy", int'(bus.busy), 0);

        // table of frame payloads
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            load_ram(vecs[v].ram_word);
            push_frame(vecs[v].ram_word, vecs[v].csum);
            pulse_tick();
            wait_sent(400);
            step(3);
            check("frame_sent_cnt", frame_sent_cnt, 1);
            check("bytes_left", exp_q.size(), 0);
            check("rd_en_cnt", rd_en_cnt, FB);
            for (int i = 0; i < rd_log.size() && i < FB; i++) check("rd_addr", rd_log[i], i);
            check("frame_overrun", overrun_cnt, 0);
            check("frame_busy_after", int'(bus.busy), 0);
            check_frame_timing();
            step($urandom_range(1, 5));
        end

        // frame_tick and msg_valid on the same cycle: frame wins
        clear_logs();
        load_ram(32'h01020304);
        push_frame(32'h01020304, 8'h0A);
        exp_q.push_back(8'h3C);
        bus.frame_tick = 1'b1;
        bus.msg_valid  = 1'b1;
        bus.msg_data   = 8'h3C;
        step(1);
        bus.frame_tick = 1'b0;
        wait_sent(400);
        check("msg_held_during_frame", msg_ready_cnt, 0);
        wait_msg_ready(20);
        bus.msg_valid = 1'b0;
        wait_dones(10, 40);
        step(3);
        check("msg_ready_once", msg_ready_cnt, 1);
        check("msg_after_frame", int'(msg_ready_cyc > frame_sent_cyc), 1);
        check("tie_bytes_left", exp_q.size(), 0);
        check("tie_busy_after", int'(bus.busy), 0);

        // frame_tick while a status byte is in flight
        clear_logs();
        exp_q.push_back(8'h3C);
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'h3C;
        wait_msg_ready(20);
        bus.msg_valid = 1'b0;
        step(2);
        push_frame(32'h01020304, 8'h0A);
        pulse_tick();
        wait_sent(400);
        step(3);
        check("pend_overrun", overrun_cnt, 0);
        check("pend_msg_ready", msg_ready_cnt, 1);
        check("pend_bytes_left", exp_q.size(), 0);
        if (start_cyc_q.size() >= 2 && done_cyc_q.size() >= 1)
            check("msg_to_hdr_gap", start_cyc_q[1] - done_cyc_q[0], 1);
        else
            note_fail("pend_event_count", start_cyc_q.size());

        // second frame_tick during payload byte 2 is dropped
        clear_logs();
        push_frame(32'h01020304, 8'h0A);
        pulse_tick();
        wait_starts(7, 200);
        pulse_tick();
        wait_sent(400);
        step(30);
        check("ovr_overrun_cnt", overrun_cnt, 1);
        check("ovr_byte_cnt", tx_start_cnt, 9);
        check("ovr_frame_sent", frame_sent_cnt, 1);
        check("ovr_busy_after", int'(bus.busy), 0);
        check("ovr_bytes_left", exp_q.size(), 0);

        // reset during payload byte 1, then a clean restart
        clear_logs();
        push_frame(32'h01020304, 8'h0A);
        pulse_tick();
        wait_starts(6, 200);
        step(1);
        reset = 1'b1;
        #1;
        check_quiet_outputs("midreset");
        exp_q.delete();
        step(2);
        reset = 1'b0;
        clear_logs();
        step(40);
        check("post_reset_no_start", tx_start_cnt, 0);
        check("post_reset_busy", int'(bus.busy), 0);
        load_ram(32'hAABBCCDD);
        push_frame(32'hAABBCCDD, 8'h0E);
        pulse_tick();
        wait_sent(400);
        step(3);
        check("restart_frame_sent", frame_sent_cnt, 1);
        check("restart_bytes_left", exp_q.size(), 0);
        check("restart_rd_en_cnt", rd_en_cnt, FB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
